wb_arbiter: RTL and testbench

- Shares the scoreboard writeback ports between the functional units.
- Each cycle it selects up to NR_WB_PORTS results from NR_REQ requesters (ALU, branch, CSR, MULT, LOAD, STORE) using rotating priority.
- Selected results are registered onto the writeback ports.
- Sits between the EX-stage units and the scoreboard; the scoreboard always accepts a writeback.

---
 rtl/ariane_pkg.sv | 23 ++
 rtl/wb_arbiter_rr_pick.sv | 44 ++++
 rtl/wb_arbiter.sv | 103 ++++++++++
 tb/tb_wb_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared types for the EX-stage writeback path: result requests, exceptions
// and the writeback port count.
package ariane_pkg;

    localparam int unsigned NR_WB_PORTS   = 4;
    localparam int unsigned NR_FU_WB      = 6;
    localparam int unsigned TRANS_ID_BITS = 3;

    localparam logic [63:0] LD_ACCESS_FAULT = 64'd5;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [63:0]              data;
        exception_t               ex;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Rotating-priority selector: scans N requesters from ptr_i with modulo-N wrap
// and packs up to M winners into slots 0..M-1 in scan order.
module rr_pick #(
    parameter int unsigned N  = 6,
    parameter int unsigned M  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]         valid_i,
    input  logic [PW-1:0]        ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [M-1:0][PW-1:0] idx_o,
    output logic [M-1:0]         slot_vld_o,
    output logic [PW-1:0]        next_ptr_o
);

    localparam int unsigned CW = $clog2(M + 1);

    logic [CW-1:0] cnt;
    logic [PW:0]   sum;
    logic [PW-1:0] pos;

    always_comb begin
        grant_o    = '0;
        idx_o      = '0;
        slot_vld_o = '0;
        next_ptr_o = ptr_i;
        cnt        = '0;
        sum        = '0;
        pos        = '0;
        for (int j = 0; j < N; j++) begin
            // N need not be a power of two, so the wrap is an explicit subtract
            sum = {1'b0, ptr_i} + (PW+1)'(j);
            pos = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
            if (valid_i[pos] && (cnt < CW'(M))) begin
                grant_o[pos]    = 1'b1;
                slot_vld_o[cnt] = 1'b1;
                idx_o[cnt]      = pos;
                next_ptr_o      = (pos == PW'(N - 1)) ? '0 : pos + PW'(1);
                cnt             = cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to NR_WB_PORTS of NR_REQ functional-unit results
// per cycle with rotating priority and registers them onto the scoreboard ports.
module wb_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NR_REQ      = NR_FU_WB,
    parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        flush_i,
    input  logic [NR_REQ-1:0]                           req_valid_i,
    output logic [NR_REQ-1:0]                           req_ready_o,
    input  wb_req_t [NR_REQ-1:0]                        req_i,
    output logic [NR_WB_PORTS-1:0]                      wb_valid_o,
    output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [NR_WB_PORTS-1:0][63:0]                wb_data_o,
    output exception_t [NR_WB_PORTS-1:0]                wb_ex_o
);

    localparam int unsigned PW = $clog2(NR_REQ);

    logic [PW-1:0]                   ptr_q, ptr_d, next_ptr;
    logic [NR_REQ-1:0]               grant;
    logic [NR_WB_PORTS-1:0][PW-1:0]  slot_idx;
    logic [NR_WB_PORTS-1:0]          slot_vld;
    logic                            kill;

    logic [NR_WB_PORTS-1:0]                    wb_valid_q, wb_valid_d;
    logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_q, wb_trans_id_d;
    logic [NR_WB_PORTS-1:0][63:0]              wb_data_q, wb_data_d;
    exception_t [NR_WB_PORTS-1:0]              wb_ex_q, wb_ex_d;

    rr_pick #(
        .N  (NR_REQ),
        .M  (NR_WB_PORTS),
        .PW (PW)
    ) i_rr_pick (
        .valid_i    (req_valid_i),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .idx_o      (slot_idx),
        .slot_vld_o (slot_vld),
        .next_ptr_o (next_ptr)
    );

    assign kill        = rst_i | flush_i;
    assign req_ready_o = kill ? '0 : grant;

    always_comb begin
        ptr_d         = ptr_q;
        wb_valid_d    = '0;
        wb_trans_id_d = '0;
        wb_data_d     = '0;
        wb_ex_d       = '0;
        if (flush_i) begin
            ptr_d = '0;
        end else if (|grant) begin
            ptr_d = next_ptr;
        end
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            if (slot_vld[k] && !kill) begin
                wb_valid_d[k]    = 1'b1;
                wb_trans_id_d[k] = req_i[slot_idx[k]].trans_id;
                wb_data_d[k]     = req_i[slot_idx[k]].data;
                wb_ex_d[k]       = req_i[slot_idx[k]].ex;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q         <= '0;
            wb_valid_q    <= '0;
            wb_trans_id_q <= '0;
            wb_data_q     <= '0;
            wb_ex_q       <= '0;
        end else begin
            ptr_q         <= ptr_d;
            wb_valid_q    <= wb_valid_d;
            wb_trans_id_q <= wb_trans_id_d;
            wb_data_q     <= wb_data_d;
            wb_ex_q       <= wb_ex_d;
        end
    end

    assign wb_valid_o    = wb_valid_q;
    assign wb_trans_id_o = wb_trans_id_q;
    assign wb_data_o     = wb_data_q;
    assign wb_ex_o       = wb_ex_q;

`ifndef SYNTHESIS
    // Two live results aimed at the same scoreboard slot would corrupt it
    for (genvar a = 0; a < NR_REQ; a++) begin : g_tid_a
        for (genvar b = a + 1; b < NR_REQ; b++) begin : g_tid_b
            a_unique_tid: assert property (@(posedge clk_i) disable iff (rst_i)
                !(req_valid_i[a] && req_valid_i[b] &&
                  (req_i[a].trans_id == req_i[b].trans_id)));
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run,
// all checked against a queue-based rotating-priority reference model.
module tb_wb_arbiter;
    import ariane_pkg::*;

    localparam int NR_REQ = 6;
    localparam int NR_WB  = 4;

    logic                           clk = 1'b0;
    logic                           rst_i, flush_i;
    logic [NR_REQ-1:0]              req_valid_i, req_ready_o;
    wb_req_t [NR_REQ-1:0]           req_i;
    logic [NR_WB-1:0]               wb_valid_o;
    logic [NR_WB-1:0][2:0]          wb_trans_id_o;
    logic [NR_WB-1:0][63:0]         wb_data_o;
    exception_t [NR_WB-1:0]         wb_ex_o;

    wb_arbiter #(.NR_REQ(NR_REQ), .NR_WB_PORTS(NR_WB)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_i         (req_i),
        .wb_valid_o    (wb_valid_o),
        .wb_trans_id_o (wb_trans_id_o),
        .wb_data_o     (wb_data_o),
        .wb_ex_o       (wb_ex_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int                      m_ptr = 0, nxt_ptr = 0;
    logic [NR_REQ-1:0]       exp_ready;
    logic [NR_WB-1:0]        exp_valid = '0, nxt_valid;
    logic [NR_WB-1:0][2:0]   exp_tid = '0, nxt_tid;
    logic [NR_WB-1:0][63:0]  exp_data = '0, nxt_data;
    exception_t [NR_WB-1:0]  exp_ex = '0, nxt_ex;

    // Build the grant list by walking requesters in priority order from the
    // pointer and taking the first NR_WB valid ones.
    task automatic model_eval();
        int q[$];
        int r;
        #1;
        exp_ready = '0; nxt_valid = '0; nxt_tid = '0; nxt_data = '0; nxt_ex = '0;
        nxt_ptr = m_ptr;
        if (rst_i || flush_i) begin
            nxt_ptr = 0;
            return;
        end
        for (int j = 0; j < NR_REQ; j++) begin
            r = (m_ptr + j) % NR_REQ;
            if (req_valid_i[r] && q.size() < NR_WB) q.push_back(r);
        end
        foreach (q[i]) begin
            exp_ready[q[i]] = 1'b1;
            nxt_valid[i]    = 1'b1;
            nxt_tid[i]      = req_i[q[i]].trans_id;
            nxt_data[i]     = req_i[q[i]].data;
            nxt_ex[i]       = req_i[q[i]].ex;
        end
        if (q.size() > 0) nxt_ptr = (q[q.size()-1] + 1) % NR_REQ;
    endtask

    task automatic step();
        @(posedge clk);
        exp_valid = nxt_valid; exp_tid = nxt_tid; exp_data = nxt_data; exp_ex = nxt_ex;
        m_ptr = nxt_ptr;
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] tid, input logic [63:0] d,
                           input logic exv, input logic [63:0] cause);
        req_i[r].trans_id = tid;
        req_i[r].data     = d;
        req_i[r].ex.valid = exv;
        req_i[r].ex.cause = cause;
        req_i[r].ex.tval  = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '1;
        for (int c = 0; c < 2; c++) begin
            model_eval();
            n_cmp++;
            if (req_ready_o !== 6'b0) begin
                n_err++; $display("FAIL reset_ready: got %b want 000000", req_ready_o);
            end
            step();
        end
        rst_i = 1'b0; req_valid_i = '0;
        n_cmp++;
        if ({wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o} !== '0) begin
            n_err++; $display("FAIL reset_wb: valid %b tid %h want all zero", wb_valid_o, wb_trans_id_o);
        end
        model_eval();
        step();
        n_cmp++;
        if (wb_valid_o !== 4'b0000) begin
            n_err++; $display("FAIL reset_release_wb: valid %b want 0000", wb_valid_o);
        end
    endtask

    task automatic test_under();
        for (int r = 0; r < NR_REQ; r++) set_req(r, 3'(r + 1), {$urandom, $urandom}, 1'b0, 64'd0);
        set_req(0, 3'd3, 64'h1111_0000_0000_0003, 1'b0, 64'd0);
        set_req(2, 3'd5, 64'h2222_0000_0000_0005, 1'b0, 64'd0);
        set_req(4, 3'd0, 64'h0, 1'b0, 64'd0);
        req_valid_i = 6'b000101;
        model_eval();
        n_cmp++;
        if (req_ready_o !== exp_ready || req_ready_o !== 6'b000101) begin
            n_err++; $display("FAIL under_ready: got %b want %b", req_ready_o, exp_ready);
        end
        step();
        req_valid_i = '0;
        n_cmp++;
        if ({wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o} !== {exp_valid, exp_tid, exp_data, exp_ex}) begin
            n_err++; $display("FAIL under_wb: valid %b/%b tid %h/%h", wb_valid_o, exp_valid, wb_trans_id_o, exp_tid);
        end
        n_cmp++;
        if (wb_valid_o !== 4'b0011 || wb_trans_id_o[0] !== 3'd3 || wb_trans_id_o[1] !== 3'd5
            || dut.ptr_q !== 3'd3) begin
            n_err++; $display("FAIL under_ports: valid %b tid0 %0d tid1 %0d ptr %0d want 0011 3 5 3",
                              wb_valid_o, wb_trans_id_o[0], wb_trans_id_o[1], dut.ptr_q);
        end
    endtask

    task automatic test_rotation();
        int cnt[NR_REQ];
        int ptr_seq[3] = '{4, 2, 0};
        flush_i = 1'b1; req_valid_i = '0;
        model_eval(); step();
        flush_i = 1'b0;
        n_cmp++;
        if (dut.ptr_q !== 3'd0) begin
            n_err++; $display("FAIL rot_flush_ptr: got %0d want 0", dut.ptr_q);
        end
        for (int r = 0; r < NR_REQ; r++) begin
            set_req(r, 3'(r), {$urandom, $urandom}, 1'b0, 64'd0);
            cnt[r] = 0;
        end
        req_valid_i = '1;
        for (int c = 0; c < 3; c++) begin
            model_eval();
            n_cmp++;
            if (req_ready_o !== exp_ready) begin
                n_err++; $display("FAIL rot_ready%0d: got %b want %b", c, req_ready_o, exp_ready);
            end
            for (int r = 0; r < NR_REQ; r++) if (req_ready_o[r]) cnt[r]++;
            step();
            for (int r = 0; r < NR_REQ; r++)
                if (exp_ready[r]) req_i[r].data = {$urandom, $urandom};
            n_cmp++;
            if ({wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o} !== {exp_valid, exp_tid, exp_data, exp_ex}) begin
                n_err++; $display("FAIL rot_wb%0d: valid %b/%b tid %h/%h", c, wb_valid_o, exp_valid, wb_trans_id_o, exp_tid);
            end
            n_cmp++;
            if (dut.ptr_q !== 3'(ptr_seq[c])) begin
                n_err++; $display("FAIL rot_ptr%0d: got %0d want %0d", c, dut.ptr_q, ptr_seq[c]);
            end
        end
        for (int r = 0; r < NR_REQ; r++) begin
            n_cmp++;
            if (cnt[r] != 2) begin
                n_err++; $display("FAIL rot_count req%0d: got %0d want 2", r, cnt[r]);
            end
        end
        req_valid_i = '0;
    endtask

    task automatic test_wrap();
        req_valid_i = 6'b010000;
        model_eval(); step();
        n_cmp++;
        if (dut.ptr_q !== 3'd5) begin
            n_err++; $display("FAIL wrap_setup_ptr: got %0d want 5", dut.ptr_q);
        end
        req_valid_i = 6'b100011;
        model_eval();
        n_cmp++;
        if (req_ready_o !== exp_ready) begin
            n_err++; $display("FAIL wrap_ready: got %b want %b", req_ready_o, exp_ready);
        end
        step();
        req_valid_i = '0;
        n_cmp++;
        if ({wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o} !== {exp_valid, exp_tid, exp_data, exp_ex}) begin
            n_err++; $display("FAIL wrap_wb: valid %b/%b tid %h/%h", wb_valid_o, exp_valid, wb_trans_id_o, exp_tid);
        end
        n_cmp++;
        if (wb_valid_o !== 4'b0111 || wb_trans_id_o[0] !== 3'd5 || wb_trans_id_o[1] !== 3'd0
            || wb_trans_id_o[2] !== 3'd1 || dut.ptr_q !== 3'd2) begin
            n_err++; $display("FAIL wrap_ports: valid %b tid %h ptr %0d want 0111 r5,r0,r1 ptr 2",
                              wb_valid_o, wb_trans_id_o, dut.ptr_q);
        end
    endtask

    task automatic test_flush();
        req_valid_i = '1;
        model_eval(); step();
        flush_i = 1'b1;
        model_eval();
        n_cmp++;
        if (req_ready_o !== 6'b0 || req_ready_o !== exp_ready) begin
            n_err++; $display("FAIL flush_ready: got %b want 000000", req_ready_o);
        end
        n_cmp++;
        if ({wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o} !== {exp_valid, exp_tid, exp_data, exp_ex}
            || wb_valid_o !== 4'b1111) begin
            n_err++; $display("FAIL flush_prev_wb: valid %b/%b tid %h/%h", wb_valid_o, exp_valid, wb_trans_id_o, exp_tid);
        end
        step();
        flush_i = 1'b0; req_valid_i = '0;
        n_cmp++;
        if (wb_valid_o !== 4'b0000 || dut.ptr_q !== 3'd0) begin
            n_err++; $display("FAIL flush_after: valid %b ptr %0d want 0000 0", wb_valid_o, dut.ptr_q);
        end
    endtask

    task automatic test_hold();
        int seen = 0;
        logic ok = 1'b1;
        req_valid_i = 6'b001000;
        model_eval(); step();
        n_cmp++;
        if (dut.ptr_q !== 3'd4) begin
            n_err++; $display("FAIL hold_setup_ptr: got %0d want 4", dut.ptr_q);
        end
        for (int r = 0; r < NR_REQ; r++) set_req(r, 3'(r), {$urandom | 32'h1, $urandom}, 1'b0, 64'd0);
        set_req(3, 3'd6, 64'hDEAD_BEEF, 1'b1, LD_ACCESS_FAULT);
        req_valid_i = '1;
        for (int c = 0; c < 3; c++) begin
            model_eval();
            n_cmp++;
            if (req_ready_o !== exp_ready || (c == 0 && req_ready_o[3] !== 1'b0)) begin
                n_err++; $display("FAIL hold_ready%0d: got %b want %b", c, req_ready_o, exp_ready);
            end
            step();
            for (int r = 0; r < NR_REQ; r++)
                if (exp_ready[r]) begin
                    if (r == 3) req_valid_i[3] = 1'b0;
                    else req_i[r].data = {$urandom | 32'h1, $urandom};
                end
            n_cmp++;
            if ({wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o} !== {exp_valid, exp_tid, exp_data, exp_ex}) begin
                n_err++; $display("FAIL hold_wb%0d: valid %b/%b tid %h/%h", c, wb_valid_o, exp_valid, wb_trans_id_o, exp_tid);
            end
            for (int k = 0; k < NR_WB; k++)
                if (wb_valid_o[k] && wb_data_o[k] === 64'hDEAD_BEEF) begin
                    seen++;
                    if (wb_trans_id_o[k] !== 3'd6 || wb_ex_o[k].valid !== 1'b1
                        || wb_ex_o[k].cause !== LD_ACCESS_FAULT) ok = 1'b0;
                end
        end
        req_valid_i = '0;
        n_cmp++;
        if (seen != 1 || !ok) begin
            n_err++; $display("FAIL hold_once: seen %0d fields_ok %b want 1 1", seen, ok);
        end
    endtask

    task automatic test_random();
        logic [NR_REQ-1:0] vld = '0, gnt;
        int wait_cnt[NR_REQ];
        int base = $urandom_range(0, 7);
        for (int r = 0; r < NR_REQ; r++) begin
            wait_cnt[r] = 0;
            set_req(r, 3'((base + r) % 8), {$urandom, $urandom}, 1'($urandom), 64'($urandom));
        end
        for (int c = 0; c < 300; c++) begin
            flush_i = ($urandom % 16) == 0;
            rst_i = (c == 150);
            req_valid_i = vld;
            model_eval();
            gnt = exp_ready;
            n_cmp++;
            if (req_ready_o !== exp_ready) begin
                n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready_o, exp_ready);
            end
            for (int r = 0; r < NR_REQ; r++) begin
                if (gnt[r]) begin
                    n_cmp++;
                    if (wait_cnt[r] > 1) begin
                        n_err++; $display("FAIL rnd_starve req%0d: waited %0d want <=1", r, wait_cnt[r]);
                    end
                end
                if (vld[r] && !gnt[r] && !flush_i && !rst_i) wait_cnt[r]++;
                else wait_cnt[r] = 0;
            end
            step();
            n_cmp++;
            if ({wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o} !== {exp_valid, exp_tid, exp_data, exp_ex}) begin
                n_err++; $display("FAIL rnd_wb c%0d: valid %b/%b tid %h/%h", c, wb_valid_o, exp_valid, wb_trans_id_o, exp_tid);
            end
            for (int r = 0; r < NR_REQ; r++)
                if (!vld[r] || gnt[r] || flush_i || rst_i) begin
                    vld[r] = ($urandom % 3) != 0;
                    req_i[r].data     = {$urandom, $urandom};
                    req_i[r].ex.valid = 1'($urandom);
                    req_i[r].ex.cause = 64'($urandom);
                end
        end
        rst_i = 1'b0; flush_i = 1'b0; req_valid_i = '0;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '1;
        for (int r = 0; r < NR_REQ; r++) set_req(r, 3'(r), 64'(r), 1'b0, 64'd0);
        test_reset();
        test_under();
        test_rotation();
        test_wrap();
        test_flush();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
